// File: rtl/lcd_bus_controller_if.sv
// Host-side handshake and LCD pin bundle for lcd_bus_controller.
// The engine connects through the slave modport; the host/bench uses master.
interface lcd_bus_controller_if #(
    parameter int BUS_WIDTH = 8
);
    logic [7:0]           iDATA;
    logic                 iRS;
    logic                 iValid;
    logic                 oReady;
    logic                 oDone;
    logic [BUS_WIDTH-1:0] LCD_DATA;
    logic                 LCD_RS;
    logic                 LCD_RW;
    logic                 LCD_EN;

    modport master (
        output iDATA, iRS, iValid,
        input  oReady, oDone, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );

    modport slave (
        input  iDATA, iRS, iValid,
        output oReady, oDone, LCD_DATA, LCD_RS, LCD_RW, LCD_EN
    );
endinterface

// File: rtl/lcd_bus_controller.sv
// HD44780-style write engine: one byte per handshake, programmable setup/enable/hold
// timing, 8- or 4-bit bus, and built-in execution delay before the next byte.
module lcd_bus_controller #(
    parameter int BUS_WIDTH    = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int EN_CYCLES    = 12,
    parameter int HOLD_CYCLES  = 2,
    parameter int SHORT_DELAY  = 2000,
    parameter int LONG_DELAY   = 82000,
    parameter int CNT_W        = 18
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    lcd_bus_controller_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD,
        EXEC_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_EN    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_SHORT = CNT_W'(SHORT_DELAY - 1);
    localparam logic [CNT_W-1:0] L_LONG  = CNT_W'(LONG_DELAY - 1);

    state_t               r_state, w_state_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic [7:0]           r_byte, w_byte_next;
    logic                 r_rs, w_rs_next;
    logic [BUS_WIDTH-1:0] r_data, w_data_next;
    logic                 r_en, w_en_next;
    logic                 r_nib2, w_nib2_next;
    logic                 r_ready, w_ready_next;
    logic                 r_done, w_done_next;

    logic [BUS_WIDTH-1:0] w_first_beat;
    logic [BUS_WIDTH-1:0] w_second_beat;
    logic                 w_long;
    logic [CNT_W-1:0]     w_delay_last;

    // First beat comes straight from the host bus so it reaches the pins on the accept edge.
    generate
        if (BUS_WIDTH == 4) begin : g_bus4
            assign w_first_beat  = bus.iDATA[7:4];
            assign w_second_beat = r_byte[3:0];
        end else begin : g_bus8
            assign w_first_beat  = bus.iDATA;
            assign w_second_beat = r_byte;
        end
    endgenerate

    // Clear (0x01) and return-home (0x02/0x03) are the only slow instructions.
    assign w_long       = !r_rs && (r_byte[7:2] == 6'd0);
    assign w_delay_last = w_long ? L_LONG : L_SHORT;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_byte  <= '0;
            r_rs    <= 1'b0;
            r_data  <= '0;
            r_en    <= 1'b0;
            r_nib2  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_byte  <= w_byte_next;
            r_rs    <= w_rs_next;
            r_data  <= w_data_next;
            r_en    <= w_en_next;
            r_nib2  <= w_nib2_next;
            r_ready <= w_ready_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + CNT_W'(1);
        w_byte_next  = r_byte;
        w_rs_next    = r_rs;
        w_data_next  = r_data;
        w_en_next    = r_en;
        w_nib2_next  = r_nib2;
        w_ready_next = r_ready;
        w_done_next  = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_next = '0;
                if (bus.iValid && r_ready) begin
                    w_byte_next  = bus.iDATA;
                    w_rs_next    = bus.iRS;
                    w_data_next  = w_first_beat;
                    w_nib2_next  = 1'b0;
                    w_ready_next = 1'b0;
                    w_state_next = SETUP;
                end
            end
            SETUP: begin
                if (r_cnt == L_SETUP) begin
                    w_en_next    = 1'b1;
                    w_cnt_next   = '0;
                    w_state_next = ENABLE;
                end
            end
            ENABLE: begin
                if (r_cnt == L_EN) begin
                    w_en_next    = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (r_cnt == L_HOLD) begin
                    w_cnt_next = '0;
                    // In 4-bit mode the low nibble gets its own setup/enable/hold pass.
                    if ((BUS_WIDTH == 4) && !r_nib2) begin
                        w_data_next  = w_second_beat;
                        w_nib2_next  = 1'b1;
                        w_state_next = SETUP;
                    end else begin
                        w_state_next = EXEC_WAIT;
                    end
                end
            end
            EXEC_WAIT: begin
                if (r_cnt == w_delay_last) begin
                    w_cnt_next   = '0;
                    w_ready_next = 1'b1;
                    w_done_next  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_en_next    = 1'b0;
                w_ready_next = 1'b1;
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.oReady   = r_ready;
    assign bus.oDone    = r_done;
    assign bus.LCD_DATA = r_data;
    assign bus.LCD_RS   = r_rs;
    assign bus.LCD_RW   = 1'b0;
    assign bus.LCD_EN   = r_en;

endmodule
